// File: rtl/temp_poll_sched_if.sv
// -----------------------------------------------------------------------------
// temp_poll_sched_if
// Command/response bundle between the temperature read scheduler and the
// byte-level I2C master.
//   i2c_req    : command valid, held until i2c_ack
//   i2c_addr   : 7-bit slave address
//   i2c_reg    : register pointer
//   i2c_nbytes : number of bytes to read
//   i2c_abort  : one-cycle pulse, master returns to idle
//   i2c_ack    : one-cycle pulse, master accepted the command
//   i2c_done   : one-cycle pulse, transfer finished
//   i2c_nack   : slave NACKed, qualified by i2c_done
//   i2c_rdata  : {MSB, LSB}, qualified by i2c_done
// Modport master is the scheduler side; modport slave is the I2C master side.
// -----------------------------------------------------------------------------
interface temp_poll_sched_if;
  logic        i2c_req;
  logic [6:0]  i2c_addr;
  logic [7:0]  i2c_reg;
  logic [1:0]  i2c_nbytes;
  logic        i2c_abort;
  logic        i2c_ack;
  logic        i2c_done;
  logic        i2c_nack;
  logic [15:0] i2c_rdata;

  modport master (
    output i2c_req, i2c_addr, i2c_reg, i2c_nbytes, i2c_abort,
    input  i2c_ack, i2c_done, i2c_nack, i2c_rdata
  );

  modport slave (
    input  i2c_req, i2c_addr, i2c_reg, i2c_nbytes, i2c_abort,
    output i2c_ack, i2c_done, i2c_nack, i2c_rdata
  );
endinterface

// File: rtl/temp_poll_sched.sv
// -----------------------------------------------------------------------------
// temp_poll_sched
// Periodic read scheduler for the ADT7420 temperature register. Decides when
// the I2C master runs a 2-byte read of register 0, supervises the transfer
// with a timeout and converts the 13-bit reading to an unsigned integer degC.
//
// Ports:
//   clk_100MHz  : system clock, rising edge
//   reset       : synchronous, active-low
//   enable      : periodic scheduling on when high
//   trig        : one-cycle pulse requesting an immediate read
//   bus         : I2C master command port (temp_poll_sched_if.master)
//   temp_c      : unsigned integer degC, clamped 0..255
//   temp_raw    : last raw reading, two's complement, 0.0625 degC/LSB
//   temp_valid  : one-cycle pulse when temp_c/temp_raw update
//   err_nack    : sticky, a NACK was seen
//   err_timeout : sticky, a transfer timed out
//   sample_cnt  : successful reads, wraps
//   temp_min/temp_max : running extremes of temp_c (TEMP_POLL_MINMAX_EN only)
//
// Build option: define TEMP_POLL_MINMAX_EN to add the temp_min/temp_max ports.
// -----------------------------------------------------------------------------
module temp_poll_sched #(
  parameter int unsigned SAMPLE_PERIOD  = 100_000_000,
  parameter int unsigned TIMEOUT_CYCLES = 50_000,
  parameter logic [6:0]  DEV_ADDR       = 7'h4B
) (
  input  logic                     clk_100MHz,
  input  logic                     reset,
  input  logic                     enable,
  input  logic                     trig,
  temp_poll_sched_if.master        bus,
  output logic [7:0]               temp_c,
  output logic [12:0]              temp_raw,
  output logic                     temp_valid,
  output logic                     err_nack,
  output logic                     err_timeout,
  output logic [15:0]              sample_cnt
`ifdef TEMP_POLL_MINMAX_EN
  ,
  output logic [7:0]               temp_min,
  output logic [7:0]               temp_max
`endif
);

  localparam int PER_W = $clog2(SAMPLE_PERIOD);
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [PER_W-1:0] PER_LAST = PER_W'(SAMPLE_PERIOD - 1);
  localparam logic [TMO_W-1:0] TMO_LOAD = TMO_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, REQ, XFER, PROC} state_t;

  state_t                    state, state_n;
  logic                      pending;
  logic [PER_W-1:0]          per_cnt;
  logic [TMO_W-1:0]          tmo_cnt;
  logic signed [12:0]        rdata_p0;
  logic [7:0]                new_c;
  logic                      period_tick;
  logic                      consume;
  logic                      load_tmo;
  logic                      tmo_expire;
  logic                      do_nack;
  logic                      do_latch;
  logic                      rdata_lsb_unused;

  // Integer part is raw/16 (floor); negative temperatures clamp to zero and the
  // positive range tops out at 255 so no upper clamp is needed.
  function automatic logic [7:0] to_celsius(input logic signed [12:0] raw);
    if (raw < 0) return 8'h00;
    return raw[11:4];
  endfunction

  assign bus.i2c_addr   = DEV_ADDR;
  assign bus.i2c_reg    = 8'h00;
  assign bus.i2c_nbytes = 2'd2;

  assign period_tick      = enable && (per_cnt == PER_LAST);
  assign new_c            = to_celsius(rdata_p0);
  assign rdata_lsb_unused = ^bus.i2c_rdata[2:0];

  always_ff @(posedge clk_100MHz) begin
    if (!reset) begin
      state   <= IDLE;
      pending <= 1'b0;
      per_cnt <= '0;
    end else begin
      state <= state_n;
      // An event arriving on the same edge that IDLE consumes pending re-arms it.
      pending <= trig | period_tick | (pending & ~consume);
      if (!enable || period_tick) per_cnt <= '0;
      else                        per_cnt <= per_cnt + 1'b1;
    end
  end

  always_comb begin
    state_n    = state;
    consume    = 1'b0;
    load_tmo   = 1'b0;
    tmo_expire = 1'b0;
    do_nack    = 1'b0;
    do_latch   = 1'b0;
    case (state)
      IDLE: if (pending) begin
        state_n = REQ;
        consume = 1'b1;
      end
      REQ: if (bus.i2c_ack) begin
        state_n  = XFER;
        load_tmo = 1'b1;
      end
      XFER: begin
        // done takes priority over a timeout expiring on the same edge
        if (bus.i2c_done) begin
          if (bus.i2c_nack) begin
            do_nack = 1'b1;
            state_n = IDLE;
          end else begin
            do_latch = 1'b1;
            state_n  = PROC;
          end
        end else if (tmo_cnt == '0) begin
          tmo_expire = 1'b1;
          state_n    = IDLE;
        end
      end
      PROC:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Capture stage: timeout counter and raw reading; only meaningful once loaded.
  always_ff @(posedge clk_100MHz) begin
    if (load_tmo)                              tmo_cnt <= TMO_LOAD;
    else if (state == XFER && tmo_cnt != '0)   tmo_cnt <= tmo_cnt - 1'b1;
    if (do_latch) rdata_p0 <= bus.i2c_rdata[15:3];
  end

  // Output stage: command, status and converted result registers.
  always_ff @(posedge clk_100MHz) begin
    if (!reset) begin
      bus.i2c_req   <= 1'b0;
      bus.i2c_abort <= 1'b0;
      temp_valid    <= 1'b0;
      err_nack      <= 1'b0;
      err_timeout   <= 1'b0;
      sample_cnt    <= '0;
      temp_c        <= '0;
      temp_raw      <= '0;
`ifdef TEMP_POLL_MINMAX_EN
      temp_min      <= 8'hFF;
      temp_max      <= 8'h00;
`endif
    end else begin
      // req follows the state by one cycle, so it drops the edge after ack
      bus.i2c_req   <= (state == REQ);
      bus.i2c_abort <= tmo_expire;
      temp_valid    <= (state == PROC);
      if (do_nack)    err_nack    <= 1'b1;
      if (tmo_expire) err_timeout <= 1'b1;
      if (state == PROC) begin
        sample_cnt <= sample_cnt + 16'd1;
        temp_c     <= new_c;
        temp_raw   <= rdata_p0;
`ifdef TEMP_POLL_MINMAX_EN
        if (new_c < temp_min) temp_min <= new_c;
        if (new_c > temp_max) temp_max <= new_c;
`endif
      end
    end
  end

endmodule

// File: tb/tb_temp_poll_sched.sv
module tb_temp_poll_sched;
  localparam int unsigned SP = 16;
  localparam int unsigned TO = 20;

  logic        clk_100MHz = 1'b0;
  logic        reset;
  logic        enable;
  logic        trig;
  logic [7:0]  temp_c;
  logic [12:0] temp_raw;
  logic        temp_valid;
  logic        err_nack;
  logic        err_timeout;
  logic [15:0] sample_cnt;
`ifdef TEMP_POLL_MINMAX_EN
  logic [7:0]  temp_min;
  logic [7:0]  temp_max;
`endif

  temp_poll_sched_if bus();

  temp_poll_sched #(
    .SAMPLE_PERIOD (SP),
    .TIMEOUT_CYCLES(TO),
    .DEV_ADDR      (7'h4B)
  ) dut (
    .clk_100MHz (clk_100MHz),
    .reset      (reset),
    .enable     (enable),
    .trig       (trig),
    .bus        (bus),
    .temp_c     (temp_c),
    .temp_raw   (temp_raw),
    .temp_valid (temp_valid),
    .err_nack   (err_nack),
    .err_timeout(err_timeout),
    .sample_cnt (sample_cnt)
`ifdef TEMP_POLL_MINMAX_EN
    ,
    .temp_min   (temp_min),
    .temp_max   (temp_max)
`endif
  );

  always #5 clk_100MHz = ~clk_100MHz;

  typedef struct {
    logic [7:0]  c;
    logic [12:0] raw;
  } exp_t;

  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  int   req_rises[$];
  exp_t exp_q[$];
  logic req_prev = 1'b0;
  logic req_rise_now;
  int   last_ack_cyc = 0;
  int   last_abort_cyc = 0;
  int   abort_cnt = 0;
  int   valid_cnt = 0;

  // slave model controls
  logic        auto_on = 1'b0;
  int          sl_phase = 0;
  int          sl_wait = 0;
  int          sl_lat = 0;
  logic        sl_nack = 1'b0;
  logic        sl_rd_fixed_en = 1'b0;
  logic [15:0] sl_rd_fixed = 16'h0000;

  // reference model
  int          m_cnt;
  logic [7:0]  m_c;
  logic [12:0] m_raw;
  logic        m_nack;
  logic        m_tmo;
  int          m_aborts = 0;
  logic [7:0]  m_min;
  logic [7:0]  m_max;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // degC = floor(signed reading * 0.0625), clamped to 0..255
  function automatic logic [7:0] conv(input logic [15:0] rd);
    int r;
    int d;
    r = int'(rd[15:3]);
    if (rd[15]) r = r - 8192;
    if (r >= 0) d = r / 16;
    else        d = -((-r + 15) / 16);
    if (d < 0)   d = 0;
    if (d > 255) d = 255;
    return 8'(d);
  endfunction

  task automatic model_reset();
    m_cnt  = 0;
    m_c    = 8'h00;
    m_raw  = 13'h0000;
    m_nack = 1'b0;
    m_tmo  = 1'b0;
    m_min  = 8'hFF;
    m_max  = 8'h00;
    exp_q.delete();
    sl_phase = 0;
  endtask

  task automatic slave_act();
    logic [15:0] rd;
    exp_t e;
    if (sl_phase == 0) begin
      if (req_rise_now) begin
        bus.i2c_ack  = 1'b1;
        last_ack_cyc = cyc + 1;
        sl_phase     = 1;
        sl_wait      = sl_lat;
      end
    end else if (sl_wait != 0) begin
      sl_wait--;
    end else if (sl_lat >= int'(TO)) begin
      // slave never answers: the scheduler must have aborted by now
      m_aborts++;
      m_tmo    = 1'b1;
      sl_phase = 0;
    end else begin
      rd = sl_rd_fixed_en ? sl_rd_fixed : 16'($urandom);
      bus.i2c_rdata = rd;
      bus.i2c_done  = 1'b1;
      bus.i2c_nack  = sl_nack;
      if (sl_nack) begin
        m_nack = 1'b1;
      end else begin
        e.c   = conv(rd);
        e.raw = rd[15:3];
        exp_q.push_back(e);
        m_cnt++;
        m_c   = e.c;
        m_raw = e.raw;
        if (e.c < m_min) m_min = e.c;
        if (e.c > m_max) m_max = e.c;
      end
      sl_phase = 0;
    end
  endtask

  task automatic step();
    exp_t e;
    @(posedge clk_100MHz);
    #1;
    cyc++;
    bus.i2c_ack   = 1'b0;
    bus.i2c_done  = 1'b0;
    bus.i2c_nack  = 1'($urandom);
    bus.i2c_rdata = 16'($urandom);
    req_rise_now = bus.i2c_req && !req_prev;
    if (req_rise_now) req_rises.push_back(cyc);
    req_prev = bus.i2c_req;
    if (bus.i2c_abort) begin
      abort_cnt++;
      last_abort_cyc = cyc;
    end
    if (temp_valid) begin
      valid_cnt++;
      check("valid_expected", 32'(temp_valid), 32'(exp_q.size() != 0));
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("valid_temp_c", 32'(temp_c), 32'(e.c));
        check("valid_temp_raw", 32'(temp_raw), 32'(e.raw));
      end
    end
    if (auto_on) slave_act();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_trig();
    trig = 1'b1;
    step();
    trig = 1'b0;
  endtask

  task automatic check_state();
    check("st_temp_c", 32'(temp_c), 32'(m_c));
    check("st_temp_raw", 32'(temp_raw), 32'(m_raw));
    check("st_sample_cnt", 32'(sample_cnt), 32'(16'(m_cnt)));
    check("st_err_nack", 32'(err_nack), 32'(m_nack));
    check("st_err_timeout", 32'(err_timeout), 32'(m_tmo));
    check("st_aborts", abort_cnt, m_aborts);
    check("st_outstanding_valids", 32'(exp_q.size()), 0);
    check("st_req_idle", 32'(bus.i2c_req), 0);
`ifdef TEMP_POLL_MINMAX_EN
    check("st_temp_min", 32'(temp_min), 32'(m_min));
    check("st_temp_max", 32'(temp_max), 32'(m_max));
`endif
  endtask

  initial begin
    int e_cyc;
    int r_cyc;
    int vc_before;
    reset         = 1'b0;
    enable        = 1'b0;
    trig          = 1'b0;
    bus.i2c_ack   = 1'b0;
    bus.i2c_done  = 1'b0;
    bus.i2c_nack  = 1'b0;
    bus.i2c_rdata = 16'h0000;
    model_reset();

    // reset state
    run(3);
    check_state();
    check("rst_temp_valid", 32'(temp_valid), 0);
    check("rst_abort", 32'(bus.i2c_abort), 0);
    check("const_addr", 32'(bus.i2c_addr), 32'h4B);
    check("const_reg", 32'(bus.i2c_reg), 0);
    check("const_nbytes", 32'(bus.i2c_nbytes), 2);

    // first read: exact trig->req, ack->req drop and done->valid timing
    reset = 1'b1;
    auto_on = 1'b1;
    run(2);
    sl_rd_fixed_en = 1'b1;
    sl_rd_fixed    = 16'h0C80;
    trig = 1'b1;
    step();                                   // edge N
    trig = 1'b0;
    step();                                   // N+1
    check("trig_req_n1", 32'(bus.i2c_req), 0);
    step();                                   // N+2, slave acks for N+3
    check("trig_req_n2", 32'(bus.i2c_req), 1);
    step();                                   // N+3 = ack edge
    check("ack_req_m", 32'(bus.i2c_req), 1);
    step();                                   // ack+1 = done edge
    check("ack_req_m1", 32'(bus.i2c_req), 0);
    check("done_valid_d", 32'(temp_valid), 0);
    step();                                   // done+1
    check("done_valid_d1", 32'(temp_valid), 1);
    check("t1_temp_raw", 32'(temp_raw), 32'h0190);
    check("t1_temp_c", 32'(temp_c), 25);
    check("t1_sample_cnt", 32'(sample_cnt), 1);
    step();
    check("valid_pulse_width", 32'(temp_valid), 0);
    run(5);
    check_state();

    // negative reading clamps to 0
    sl_rd_fixed = 16'hE480;
    do_trig();
    run(12);
    check("t2_temp_c", 32'(temp_c), 0);
    check("t2_temp_raw", 32'(temp_raw), 32'h1C90);
`ifdef TEMP_POLL_MINMAX_EN
    check("t2_temp_min", 32'(temp_min), 0);
    check("t2_temp_max", 32'(temp_max), 25);
`endif
    check_state();

    // timeout: slave never completes
    sl_lat = 30;
    last_abort_cyc = 0;
    do_trig();
    run(40);
    check("tmo_abort_edge", last_abort_cyc - last_ack_cyc, TO);
    check("tmo_err", 32'(err_timeout), 1);
    check_state();
    sl_lat = 0;

    // next trig still served
    sl_rd_fixed = 16'h1900;
    do_trig();
    run(12);
    check("tmo_recover_c", 32'(temp_c), 50);
    check_state();

    // NACK: error set, data untouched
    sl_nack = 1'b1;
    do_trig();
    run(12);
    sl_nack = 1'b0;
    check("nack_err", 32'(err_nack), 1);
    check("nack_temp_c", 32'(temp_c), 50);
    check_state();

    // done on the expiry edge wins over the abort
    sl_lat = int'(TO) - 1;
    sl_rd_fixed = 16'h0A00;
    do_trig();
    run(35);
    sl_lat = 0;
    check("expiry_done_c", 32'(temp_c), 20);
    check_state();

    // stray ack/done while idle are ignored
    auto_on = 1'b0;
    bus.i2c_ack   = 1'b1;
    bus.i2c_done  = 1'b1;
    bus.i2c_nack  = 1'b0;
    bus.i2c_rdata = 16'h7FF8;
    run(6);
    check_state();
    auto_on = 1'b1;

    // randomized reads: data, latency, NACK, occasional second trig in flight
    sl_rd_fixed_en = 1'b0;
    for (int t = 0; t < 24; t++) begin
      sl_lat  = $urandom_range(0, 24);
      sl_nack = ($urandom_range(0, 4) == 0);
      do_trig();
      if ($urandom_range(0, 3) == 0) begin
        step();
        trig = 1'b1;
        step();
        trig = 1'b0;
      end
      run(70);
      check_state();
    end
    sl_nack = 1'b0;
    sl_lat  = 0;

    // periodic mode: first tick 16 edges after enable, then every 16 cycles
    req_rises.delete();
    enable = 1'b1;
    e_cyc  = cyc + 1;
    run(100);
    check("per_req_count", 32'(req_rises.size()), 6);
    if (req_rises.size() != 0)
      check("per_first_req", req_rises[0] - e_cyc, 17);
    for (int i = 1; i < req_rises.size(); i++)
      check("per_interval", req_rises[i] - req_rises[i-1], SP);

    // tick and trig both during one long transfer merge into one extra read
    req_rises.delete();
    sl_lat = 14;
    for (int k = 0; k < 40 && req_rises.size() == 0; k++) step();
    check("merge_req_seen", 32'(req_rises.size()), 1);
    r_cyc  = (req_rises.size() != 0) ? req_rises[0] : cyc;
    sl_lat = 0;
    run(4);
    trig = 1'b1;
    step();
    trig = 1'b0;
    run(40);
    check("merge_rises", 32'(req_rises.size()), 3);
    if (req_rises.size() >= 3) begin
      check("merge_extra_at", req_rises[1] - r_cyc, 19);
      check("merge_next_tick", req_rises[2] - r_cyc, 32);
    end
    enable = 1'b0;
    run(30);
    check_state();

    // reset in the middle of a transfer
    sl_lat = 30;
    do_trig();
    run(4);
    reset = 1'b0;
    auto_on = 1'b0;
    step();
    model_reset();
    check("rst_xfer_req", 32'(bus.i2c_req), 0);
    check("rst_xfer_valid", 32'(temp_valid), 0);
    check_state();
    reset = 1'b1;
    vc_before = valid_cnt;
    bus.i2c_done  = 1'b1;
    bus.i2c_nack  = 1'b0;
    bus.i2c_rdata = 16'h0C80;
    run(30);
    check("stale_done_valids", valid_cnt, vc_before);
    check_state();

    // normal service after reset
    auto_on = 1'b1;
    sl_lat  = 0;
    sl_rd_fixed_en = 1'b1;
    sl_rd_fixed    = 16'h0C80;
    do_trig();
    run(12);
    check("post_rst_cnt", 32'(sample_cnt), 1);
    check_state();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
